// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller and its FIFO.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    APPLY = 2'd2
  } rx_state_e;

  localparam logic [5:0] RESET_PRESCALE      = 6'd16;
  localparam logic       RESET_PARITY_ENABLE = 1'b0;
  localparam logic       RESET_PARITY_TYPE   = 1'b0;

  // Payload width of a buffered entry; the controller's DATA_WIDTH must equal this.
  localparam int RX_DATA_WIDTH = 8;

  typedef struct packed {
    logic                     frame_error;
    logic                     parity_error;
    logic [RX_DATA_WIDTH-1:0] data;
  } rx_entry_t;

  localparam int ENTRY_W = $bits(rx_entry_t);

  function automatic int frame_cnt_width(input int data_width);
    return $clog2(63 * (data_width + 3) + 1);
  endfunction

endpackage

// File: rtl/uart_rx_frame_fifo.sv
// Show-ahead receive FIFO with a registered head entry and sticky overrun detection.
module uart_rx_frame_fifo
  import uart_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       UCLK,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [ENTRY_W-1:0]         wr_entry,
  input  logic                       rd_en,
  input  logic                       clr_overrun,
  output logic [ENTRY_W-1:0]         head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  rx_entry_t       mem_q [DEPTH];
  rx_entry_t       head_q, head_d, wr_e;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q, rd_next;
  logic [LW-1:0]   level_q, level_d;
  logic            overrun_q, overrun_d;
  logic            do_push, do_pop, overrun_set;

  assign wr_e        = rx_entry_t'(wr_entry);
  assign empty       = (level_q == '0);
  assign full        = (level_q == LW'(DEPTH));
  assign do_pop      = rd_en & ~empty;
  assign do_push     = wr_en & (~full | do_pop);
  assign overrun_set = wr_en & full & ~do_pop;
  assign rd_next     = rd_ptr_q + 1'b1;

  // With a single entry left, the following head is the one being written this cycle.
  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    head_d = head_q;
    if (do_pop) begin
      if (level_q == LW'(1)) begin
        if (do_push) head_d = wr_e;
      end else begin
        head_d = mem_q[rd_next];
      end
    end else if (do_push && empty) begin
      head_d = wr_e;
    end

    overrun_d = overrun_q;
    if (overrun_set)      overrun_d = 1'b1;
    else if (clr_overrun) overrun_d = 1'b0;
  end

  always_ff @(posedge UCLK) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      head_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_next;
      level_q   <= level_d;
      head_q    <= head_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge UCLK) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_e;
  end

  assign head    = head_q;
  assign level   = level_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/uart_rx_frame_controller.sv
// Receiver sequencer: applies configuration between frames, tracks frame activity,
// buffers completed frames and drives the bus-side interrupt.
module uart_rx_frame_controller
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = RX_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                    UCLK,
  input  logic                    reset,
  input  logic [5:0]              cfg_prescale,
  input  logic                    cfg_parity_enable,
  input  logic                    cfg_parity_type,
  input  logic                    cfg_write,
  input  logic                    serial_data_in,
  input  logic                    rx_data_valid,
  input  logic [DATA_WIDTH-1:0]   rx_parallel_data,
  input  logic                    rx_parity_error,
  input  logic                    rx_frame_error,
  output logic [5:0]              rx_prescale,
  output logic                    rx_parity_enable,
  output logic                    rx_parity_type,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_parity_error,
  output logic                    rd_frame_error,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    busy,
  output logic                    cfg_pending,
  output logic                    overrun,
  input  logic                    clr_overrun,
  input  logic                    irq_en,
  output logic                    irq
);

  localparam int CW = frame_cnt_width(DATA_WIDTH);

  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, frame_bits, frame_load;
  logic            line_q, start_edge;
  logic [5:0]      prescale_q, pend_prescale_q;
  logic            par_en_q, par_type_q, pend_par_en_q, pend_par_type_q, pending_q;
  logic            irq_q, apply_cfg, load_cnt;
  rx_entry_t       push_entry, head;

  assign start_edge = line_q & ~serial_data_in;
  assign frame_bits = CW'(DATA_WIDTH + 2) + CW'(par_en_q);
  assign frame_load = CW'(prescale_q) * frame_bits - CW'(1);

  always_ff @(posedge UCLK) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_edge)     state_d = BUSY;
        else if (pending_q) state_d = APPLY;
      end
      BUSY:    if (cnt_q == '0) state_d = IDLE;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Settings are copied on the transition into APPLY so they are visible during it.
  always_comb begin
    busy      = (state_q == BUSY);
    apply_cfg = (state_q == IDLE) && (state_d == APPLY);
    load_cnt  = (state_q == IDLE) && (state_d == BUSY);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load_cnt)                 cnt_d = frame_load;
    else if (busy && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge UCLK) begin
    if (reset) begin
      line_q          <= 1'b1;
      cnt_q           <= '0;
      prescale_q      <= RESET_PRESCALE;
      par_en_q        <= RESET_PARITY_ENABLE;
      par_type_q      <= RESET_PARITY_TYPE;
      pend_prescale_q <= RESET_PRESCALE;
      pend_par_en_q   <= RESET_PARITY_ENABLE;
      pend_par_type_q <= RESET_PARITY_TYPE;
      pending_q       <= 1'b0;
      irq_q           <= 1'b0;
    end else begin
      line_q <= serial_data_in;
      cnt_q  <= cnt_d;
      if (apply_cfg) begin
        prescale_q <= pend_prescale_q;
        par_en_q   <= pend_par_en_q;
        par_type_q <= pend_par_type_q;
      end
      if (cfg_write) begin
        pend_prescale_q <= cfg_prescale;
        pend_par_en_q   <= cfg_parity_enable;
        pend_par_type_q <= cfg_parity_type;
        pending_q       <= 1'b1;
      end else if (apply_cfg) begin
        pending_q <= 1'b0;
      end
      irq_q <= (irq_en & ~empty) | overrun;
    end
  end

  assign push_entry = '{frame_error: rx_frame_error, parity_error: rx_parity_error,
                        data: rx_parallel_data};

  uart_rx_frame_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .UCLK        (UCLK),
    .reset       (reset),
    .wr_en       (rx_data_valid),
    .wr_entry    (push_entry),
    .rd_en       (rd_en),
    .clr_overrun (clr_overrun),
    .head        (head),
    .empty       (empty),
    .full        (full),
    .level       (level),
    .overrun     (overrun)
  );

  assign rx_prescale      = prescale_q;
  assign rx_parity_enable = par_en_q;
  assign rx_parity_type   = par_type_q;
  assign cfg_pending      = pending_q;
  assign rd_data          = head.data;
  assign rd_parity_error  = head.parity_error;
  assign rd_frame_error   = head.frame_error;
  assign irq              = irq_q;

endmodule
